// File: rtl/control_sequencer_if.sv
// ============================================================================
// Module   : control_sequencer_if
// Brief    : Control-strobe bundle between the sequencer and the bus datapath.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface control_sequencer_if;
    logic        run;
    logic [31:0] IR;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic        PCout;
    logic        PCin;
    logic        MARin;
    logic        incPC;
    logic        MDRread;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Zlow_in;
    logic        Zhigh_in;
    logic        Zlowout;
    logic [11:0] ALUin;
    logic        busy;
    logic        halted;
    logic        illegal;

    modport master (
        input  run, IR,
        output Rout, Rin, PCout, PCin, MARin, incPC, MDRread, MDRin, MDRout,
               IRin, Yin, Zlow_in, Zhigh_in, Zlowout, ALUin, busy, halted, illegal
    );

    modport slave (
        output run, IR,
        input  Rout, Rin, PCout, PCin, MARin, incPC, MDRread, MDRin, MDRout,
               IRin, Yin, Zlow_in, Zhigh_in, Zlowout, ALUin, busy, halted, illegal
    );
endinterface

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Hardwired MiniSRC control unit: fetch, then binary/unary ALU ops.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module control_sequencer #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic               clock,
    input  logic               clr,
    control_sequencer_if.master bus
);

    localparam logic [3:0] c_mem_wait = 4'(MEM_WAIT);

    localparam logic [4:0] c_op_add = 5'b00011;
    localparam logic [4:0] c_op_sub = 5'b00100;
    localparam logic [4:0] c_op_shr = 5'b00101;
    localparam logic [4:0] c_op_shl = 5'b00110;
    localparam logic [4:0] c_op_ror = 5'b00111;
    localparam logic [4:0] c_op_rol = 5'b01000;
    localparam logic [4:0] c_op_and = 5'b01001;
    localparam logic [4:0] c_op_or  = 5'b01010;
    localparam logic [4:0] c_op_neg = 5'b10000;
    localparam logic [4:0] c_op_not = 5'b10001;
    localparam logic [4:0] c_op_nop = 5'b11010;
    localparam logic [4:0] c_op_hlt = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_T0     = 4'd1,
        S_T1     = 4'd2,
        S_T2     = 4'd3,
        S_T3     = 4'd4,
        S_T4     = 4'd5,
        S_T5     = 4'd6,
        S_HALTED = 4'd7
    } state_t;

    state_t      r_state;
    logic [3:0]  r_wait_cnt;
    logic        r_illegal;

    logic [4:0]  w_opcode;
    logic [15:0] w_ra_sel;
    logic [15:0] w_rb_sel;
    logic [15:0] w_rc_sel;
    logic        w_is_binary;
    logic        w_is_unary;
    logic        w_is_nop;
    logic        w_is_halt;
    logic        w_is_illegal;
    logic [11:0] w_alu_sel;
    logic        w_unused_ir;

    assign w_opcode    = bus.IR[31:27];
    assign w_ra_sel    = 16'd1 << bus.IR[26:23];
    assign w_rb_sel    = 16'd1 << bus.IR[22:19];
    assign w_rc_sel    = 16'd1 << bus.IR[18:15];
    assign w_unused_ir = ^bus.IR[14:0];

    // Opcode classification and one-hot ALU op select
    always_comb begin
        w_is_binary = 1'b0;
        w_is_unary  = 1'b0;
        w_is_nop    = 1'b0;
        w_is_halt   = 1'b0;
        w_alu_sel   = '0;
        case (w_opcode)
            c_op_add: begin w_is_binary = 1'b1; w_alu_sel[0]  = 1'b1; end
            c_op_sub: begin w_is_binary = 1'b1; w_alu_sel[1]  = 1'b1; end
            c_op_and: begin w_is_binary = 1'b1; w_alu_sel[2]  = 1'b1; end
            c_op_or:  begin w_is_binary = 1'b1; w_alu_sel[3]  = 1'b1; end
            c_op_shr: begin w_is_binary = 1'b1; w_alu_sel[4]  = 1'b1; end
            c_op_shl: begin w_is_binary = 1'b1; w_alu_sel[5]  = 1'b1; end
            c_op_ror: begin w_is_binary = 1'b1; w_alu_sel[6]  = 1'b1; end
            c_op_rol: begin w_is_binary = 1'b1; w_alu_sel[7]  = 1'b1; end
            c_op_neg: begin w_is_unary  = 1'b1; w_alu_sel[9]  = 1'b1; end
            c_op_not: begin w_is_unary  = 1'b1; w_alu_sel[10] = 1'b1; end
            c_op_nop: w_is_nop  = 1'b1;
            c_op_hlt: w_is_halt = 1'b1;
            default:  ;
        endcase
    end

    assign w_is_illegal = ~(w_is_binary | w_is_unary | w_is_nop | w_is_halt);

    always_ff @(posedge clock) begin
        if (clr) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.run) r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T1: begin
                    if (r_wait_cnt == c_mem_wait) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_T2;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                S_T2:   r_state <= S_T3;
                S_T3: begin
                    if (w_is_binary || w_is_unary) begin
                        r_state <= S_T4;
                    end else if (w_is_halt) begin
                        r_state <= S_HALTED;
                    end else begin
                        // Undefined opcodes fall through as a nop after flagging
                        if (w_is_illegal) r_illegal <= 1'b1;
                        r_state <= S_T0;
                    end
                end
                S_T4:     r_state <= w_is_binary ? S_T5 : S_T0;
                S_T5:     r_state <= S_T0;
                S_HALTED: r_state <= S_HALTED;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes depend only on state and IR so nothing combinationally follows run
    always_comb begin
        bus.Rout     = '0;
        bus.Rin      = '0;
        bus.PCout    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MARin    = 1'b0;
        bus.incPC    = 1'b0;
        bus.MDRread  = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zlow_in  = 1'b0;
        bus.Zhigh_in = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.ALUin    = '0;
        case (r_state)
            S_T0: begin
                bus.PCout   = 1'b1;
                bus.MARin   = 1'b1;
                bus.incPC   = 1'b1;
                bus.Zlow_in = 1'b1;
            end
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.MDRread = 1'b1;
                bus.MDRin   = 1'b1;
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            S_T3: begin
                if (w_is_binary) begin
                    bus.Rout = w_rb_sel;
                    bus.Yin  = 1'b1;
                end else if (w_is_unary) begin
                    bus.Rout     = w_rb_sel;
                    bus.ALUin    = w_alu_sel;
                    bus.Zlow_in  = 1'b1;
                    bus.Zhigh_in = 1'b1;
                end
            end
            S_T4: begin
                if (w_is_binary) begin
                    bus.Rout     = w_rc_sel;
                    bus.ALUin    = w_alu_sel;
                    bus.Zlow_in  = 1'b1;
                    bus.Zhigh_in = 1'b1;
                end else if (w_is_unary) begin
                    bus.Zlowout = 1'b1;
                    bus.Rin     = w_ra_sel;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                bus.Rin     = w_ra_sel;
            end
            default: ;
        endcase
    end

    assign bus.busy    = (r_state == S_T0) || (r_state == S_T1) || (r_state == S_T2) ||
                         (r_state == S_T3) || (r_state == S_T4) || (r_state == S_T5);
    assign bus.halted  = (r_state == S_HALTED);
    assign bus.illegal = r_illegal;

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the MiniSRC bus datapath.
- Replaces hand-driven control sequences: generates every per-cycle control strobe the bus datapath consumes (register in/out selects, PC/MAR/MDR/IR/Y/Z strobes, ALU op select).
- Executes fetch, then a register-register or register-unary ALU instruction decoded from the IR the datapath returns.
- Sits directly upstream of the bus datapath. Its outputs drive the datapath's control inputs; its IR input is the datapath's IR register output.

Parameters:
- MEM_WAIT, 0: number of extra cycles the T1 memory-read state is held (0–15).

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- clr  in  1  synchronous active-high reset.
- run  in  1  start request, sampled in IDLE.
- IR  in  32  instruction register contents from datapath. Fields: opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- Rout  out  16  one-hot general-register bus-drive select (bit n = Rnout).
- Rin  out  16  one-hot general-register load select (bit n = Rnin).
- PCout, PCin, MARin, incPC  out  1 each  PC/MAR strobes.
- MDRread, MDRin, MDRout, IRin  out  1 each  memory-data strobes.
- Yin, Zlow_in, Zhigh_in, Zlowout  out  1 each  ALU operand/result strobes.
- ALUin  out  12  one-hot ALU op select. Bit assignment: 0 add, 1 sub, 2 and, 3 or, 4 shr, 5 shl, 6 ror, 7 rol, 8 mul, 9 neg, 10 not, 11 div.
- busy  out  1  high in any T-state.
- halted  out  1  high in HALTED.
- illegal  out  1  sticky; set on undefined opcode.

Behaviour:
- Clock and reset: one clock, `clock`; reset `clr` is synchronous and active-high. `clr` sampled high at a rising edge forces state=IDLE, wait counter=0, illegal=0. This holds in any state, including mid-instruction.
- Output style: all control outputs are decoded combinationally from the state register and IR only (no input-to-output path from run). In IDLE and HALTED every control output is 0. All outputs are 0 out of reset.
- IDLE: stays in IDLE while run=0; run=1 -> T0.
- T0: PCout, MARin, incPC, Zlow_in. -> T1.
- T1: Zlowout, PCin, MDRread, MDRin.
  - A 4-bit wait counter holds T1 for MEM_WAIT extra cycles, with all T1 outputs held.
  - When the counter equals MEM_WAIT: clear it and go to T2.
- T2: MDRout, IRin. -> T3. IR is valid from T3 onward.
- T3 (decode on IR[31:27]):
  - Binary ops: 00011 add, 00100 sub, 00101 shr, 00110 shl, 00111 ror, 01000 rol, 01001 and, 01010 or.
    - Drive Rout[rb] and Yin. -> T4.
  - Unary ops: 10000 neg, 10001 not.
    - Drive Rout[rb], ALUin=op bit, Zlow_in, Zhigh_in. -> T4.
  - 11010 nop: no strobes. -> T0.
  - 11011 halt: no strobes. -> HALTED.
  - Any other opcode: no strobes; set illegal. -> T0 (treated as nop).
- T4:
  - Binary: Rout[rc], ALUin=op bit, Zlow_in, Zhigh_in. -> T5.
  - Unary: Zlowout, Rin[ra]. -> T0.
- T5 (binary only): Zlowout, Rin[ra]. -> T0.
- HALTED: held until clr; run is ignored.
- Exclusivity:
  - Exactly one Rout bit at most and one Rin bit at most are set in any cycle.
  - At most one bus driver is active in any cycle: Rout|PCout|MDRout|Zlowout is one-hot or zero.
  - ALUin is nonzero only in the cycle where Zlow_in is asserted for an ALU op.
- Register operands: ra=rb=rc is legal. R0 is an ordinary register here (no zero-forcing).
- Instruction latency:
  - Binary instruction: 6 cycles (T0–T5) plus MEM_WAIT.
  - Unary instruction: 5 cycles plus MEM_WAIT.
  - nop/illegal: 4 cycles plus MEM_WAIT.
- busy is high in T0–T5 (including T1 wait cycles).

Test Plan:
- Reset: assert clr for 2 cycles from arbitrary state -> all control outputs 0, busy=0, halted=0, illegal=0. Still IDLE with run=0 for 5 cycles.
- Binary add: run=1, IR=0x1A920000 (add R5,R2,R4), MEM_WAIT=0. Required cycle by cycle:
  - T0: PCout, MARin, incPC, Zlow_in.
  - T1: Zlowout, PCin, MDRread, MDRin.
  - T2: MDRout, IRin.
  - T3: Rout=0x0004, Yin.
  - T4: Rout=0x0010, ALUin=0x001, Zlow_in, Zhigh_in.
  - T5: Zlowout, Rin=0x0020.
  - Then T0.
- Binary and: IR=0x4A920000 -> T4 ALUin=0x004.
- Unary neg: IR=0x82900000 (neg R5,R2) -> T3: Rout=0x0004, ALUin=0x200, Zlow_in, Zhigh_in; T4: Zlowout, Rin=0x0020; next cycle T0.
- Memory wait: MEM_WAIT=3 -> T1 outputs held exactly 4 consecutive cycles, then T2.
- Halt, illegal, and mid-instruction reset:
  - IR=0xF8000000 -> illegal=1 after T3, returns to T0.
  - Then IR=0xD8000000 -> halted=1, busy=0, outputs 0, run ignored.
  - clr asserted during T4 -> IDLE at next edge, illegal cleared.
